// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Decode-stage scheduler. Tracks in-flight register writers in a
//               3-slot shadow scoreboard (EX, MEM, WB) and produces the decode
//               forwarding selects, pipeline stall, IF flush and HALT drain.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int DRAIN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_early,
    input  logic             id_wr,
    input  logic [2:0]       id_dst,
    input  logic             id_load,
    input  logic             id_halt,
    input  logic             redirect,
    output logic [1:0]       fwd_A,
    output logic [1:0]       fwd_B,
    output logic             stall,
    output logic             flush_if,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int              DC_W       = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);
    localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN);
    localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef struct packed {
        logic       v;
        logic       wr;
        logic [2:0] dst;
        logic       ld;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    slot_t           ex_slot;
    slot_t           mem_slot;
    slot_t           wb_slot;
    slot_t           ex_next;
    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [DC_W-1:0] drain_cnt;
    logic [2:0]      haz_a;
    logic [2:0]      haz_b;
    logic            run;
    logic            issue;
    logic            issue_halt;

    // Per-operand hazard resolution, result is {stall, fwd[1:0]}.
    // Slots are searched youngest first so the most recent writer wins.
    function automatic logic [2:0] resolve(
        input logic [2:0] r,
        input logic       use_r,
        input logic       valid,
        input logic       early,
        input slot_t      ex,
        input slot_t      mem,
        input slot_t      wb
    );
        logic [2:0] res;
        res = 3'b000;
        if (valid && use_r) begin
            if (ex.v && ex.wr && (ex.dst == r)) begin
                // ALU result in EX is picked up by the EX-stage bypass later;
                // a load or an early consumer has to wait.
                res = {(early || ex.ld), 2'b00};
            end else if (mem.v && mem.wr && (mem.dst == r)) begin
                res = (mem.ld && early) ? 3'b100 : 3'b010;
            end else if (wb.v && wb.wr && (wb.dst == r)) begin
                res = 3'b001;
            end
        end
        return res;
    endfunction

    assign haz_a = resolve(id_rs, id_use_rs, id_valid, id_early, ex_slot, mem_slot, wb_slot);
    assign haz_b = resolve(id_rt, id_use_rt, id_valid, id_early, ex_slot, mem_slot, wb_slot);

    assign run        = (state == ST_RUN);
    assign issue      = run && !stall && id_valid;
    assign issue_halt = issue && id_halt;

    // HALT never enters EX; anything not issued becomes a bubble.
    assign ex_next = (issue && !id_halt) ? '{v: 1'b1, wr: id_wr, dst: id_dst, ld: id_load}
                                         : SLOT_EMPTY;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: RUN -> DRAIN on HALT issue, DRAIN -> HALTED when the counter runs out.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:    if (issue_halt) state_next = ST_DRAIN;
            ST_DRAIN:  if (drain_cnt <= DRAIN_LAST) state_next = ST_HALTED;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
    end

    // Output logic: stall, forwarding selects, IF flush and halted flag.
    always_comb begin
        stall    = 1'b1;
        halted   = 1'b0;
        case (state)
            ST_RUN:    stall = haz_a[2] | haz_b[2];
            ST_DRAIN:  stall = 1'b1;
            ST_HALTED: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default:   stall = 1'b1;
        endcase
        fwd_A    = stall ? 2'b00 : haz_a[1:0];
        fwd_B    = stall ? 2'b00 : haz_b[1:0];
        flush_if = redirect && id_valid && !stall && (state == ST_RUN);
    end

    // Drain counter: loaded on HALT issue, counts down while draining.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt <= '0;
        end else if (issue_halt) begin
            drain_cnt <= DRAIN_LOAD;
        end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Shadow scoreboard shift: EX -> MEM -> WB every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_slot  <= SLOT_EMPTY;
            mem_slot <= SLOT_EMPTY;
            wb_slot  <= SLOT_EMPTY;
        end else begin
            ex_slot  <= ex_next;
            mem_slot <= ex_slot;
            wb_slot  <= mem_slot;
        end
    end

    // Saturating count of hazard stall cycles while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (run && stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire
